// File: rtl/pipelined_regfile_fwd.sv
// Three-stage (decode/fetch, execute, writeback) register-file pipeline with
// optional operand forwarding from the execute and writeback stages.
module pipelined_regfile_fwd #(
    parameter int DW     = 16,
    parameter int AW     = 3,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [3+3*AW-1:0] instr,
    output logic [DW-1:0]     aluout,
    output logic              aluout_valid,
    output logic [AW-1:0]     wb_addr,
    output logic [15:0]       instr_cnt
);
    localparam int NREG = 1 << AW;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLT = 3'b101;
    localparam logic [2:0] OP_LDI = 3'b110;
    localparam logic [2:0] OP_NOP = 3'b111;

    logic [2:0]    w_op;
    logic [AW-1:0] w_rd;
    logic [AW-1:0] w_rs1;
    logic [AW-1:0] w_rs2;

    assign {w_op, w_rd, w_rs1, w_rs2} = instr;

    logic          r_s1_valid;
    logic [2:0]    r_s1_op;
    logic [AW-1:0] r_s1_rd;
    logic [AW-1:0] r_s1_rs1;
    logic [AW-1:0] r_s1_rs2;

    logic          r_s2_valid;
    logic [2:0]    r_s2_op;
    logic [AW-1:0] r_s2_rd;
    logic [DW-1:0] r_s2_a;
    logic [DW-1:0] r_s2_b;

    logic [DW-1:0] r_rf [NREG];
    logic [DW-1:0] w_alu;
    logic [DW-1:0] w_imm;

    assign w_imm = DW'({r_s1_rs1, r_s1_rs2});

    always_comb begin
        w_alu = r_s2_a;
        case (r_s2_op)
            OP_ADD:  w_alu = r_s2_a + r_s2_b;
            OP_SUB:  w_alu = r_s2_a - r_s2_b;
            OP_AND:  w_alu = r_s2_a & r_s2_b;
            OP_OR:   w_alu = r_s2_a | r_s2_b;
            OP_XOR:  w_alu = r_s2_a ^ r_s2_b;
            OP_SLT:  w_alu = ($signed(r_s2_a) < $signed(r_s2_b)) ? DW'(1) : '0;
            default: w_alu = r_s2_a;
        endcase
    end

    // Operand 0 is rs1, operand 1 is rs2; the nearer (execute) stage wins.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_opnd
            logic [AW-1:0] w_src;
            logic [DW-1:0] w_val;

            assign w_src = (gi == 0) ? r_s1_rs1 : r_s1_rs2;

            always_comb begin
                w_val = r_rf[w_src];
                if (FWD_EN && (w_src != '0)) begin
                    if (r_s2_valid && (r_s2_rd == w_src)) begin
                        w_val = w_alu;
                    end else if (aluout_valid && (wb_addr == w_src)) begin
                        w_val = aluout;
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1_valid   <= 1'b0;
            r_s1_op      <= '0;
            r_s1_rd      <= '0;
            r_s1_rs1     <= '0;
            r_s1_rs2     <= '0;
            r_s2_valid   <= 1'b0;
            r_s2_op      <= '0;
            r_s2_rd      <= '0;
            r_s2_a       <= '0;
            r_s2_b       <= '0;
            aluout       <= '0;
            aluout_valid <= 1'b0;
            wb_addr      <= '0;
            instr_cnt    <= '0;
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            // NOPs enter as bubbles so they can never be a forwarding source.
            r_s1_valid <= instr_valid && (w_op != OP_NOP);
            r_s1_op    <= w_op;
            r_s1_rd    <= w_rd;
            r_s1_rs1   <= w_rs1;
            r_s1_rs2   <= w_rs2;

            r_s2_valid <= r_s1_valid;
            r_s2_op    <= r_s1_op;
            r_s2_rd    <= r_s1_rd;
            r_s2_a     <= (r_s1_op == OP_LDI) ? w_imm : g_opnd[0].w_val;
            r_s2_b     <= g_opnd[1].w_val;

            aluout_valid <= r_s2_valid;
            if (r_s2_valid) begin
                aluout  <= w_alu;
                wb_addr <= r_s2_rd;
            end

            if (aluout_valid && (instr_cnt != 16'hFFFF)) begin
                instr_cnt <= instr_cnt + 16'd1;
            end
            if (aluout_valid && (wb_addr != '0)) begin
                r_rf[wb_addr] <= aluout;
            end
        end
    end
endmodule

// File: tb/tb_pipelined_regfile_fwd.sv
// Drives a forwarding and a legacy instance with one stimulus stream and checks
// both against an instruction-level model (sequential vs. 3-cycle-stale reads).
module tb_pipelined_regfile_fwd;
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, SLT = 3'd5, LDI = 3'd6, NOP = 3'd7;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        instr_valid = 1'b0;
    logic [11:0] instr = '0;

    logic [15:0] f_aluout, l_aluout;
    logic        f_valid, l_valid;
    logic [2:0]  f_wb, l_wb;
    logic [15:0] f_cnt, l_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: index 0 = forwarding instance, 1 = legacy instance.
    int          e = 8;
    logic [15:0] m_rf [2][8];
    bit          hv [2][8];
    logic [15:0] hd [2][8];
    logic [2:0]  ha [2][8];
    int          m_cnt [2];

    always #5 clk = ~clk;

    pipelined_regfile_fwd #(.DW(16), .AW(3), .FWD_EN(1'b1)) u_fwd (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .aluout(f_aluout), .aluout_valid(f_valid), .wb_addr(f_wb), .instr_cnt(f_cnt)
    );

    pipelined_regfile_fwd #(.DW(16), .AW(3), .FWD_EN(1'b0)) u_leg (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .aluout(l_aluout), .aluout_valid(l_valid), .wb_addr(l_wb), .instr_cnt(l_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [11:0] enc(input logic [2:0] op, input logic [2:0] rd,
                                        input logic [2:0] s1, input logic [2:0] s2);
        return {op, rd, s1, s2};
    endfunction

    function automatic logic [15:0] alu(input logic [2:0] op, input logic [15:0] a,
                                        input logic [15:0] b, input logic [5:0] imm);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
            default: return {10'd0, imm};
        endcase
    endfunction

    // One clock cycle: drive, update the model for this edge, then check both DUTs.
    task automatic step(input logic rv, input logic v, input logic [11:0] ins);
        logic [2:0] op, rd, s1, s2;
        int i0, i2, i3;
        @(negedge clk);
        rst = rv;
        instr_valid = v;
        instr = ins;
        {op, rd, s1, s2} = ins;
        e++;
        i0 = e % 8;
        i2 = (e - 2) % 8;
        i3 = (e - 3) % 8;
        for (int m = 0; m < 2; m++) begin
            if (!rv) begin
                for (int r = 0; r < 8; r++) begin
                    m_rf[m][r] = '0;
                    hv[m][r] = 1'b0;
                end
                m_cnt[m] = 0;
            end else begin
                if (hv[m][i3]) begin
                    if (m_cnt[m] < 65535) m_cnt[m]++;
                    if (m == 1 && ha[1][i3] != 3'd0) m_rf[1][ha[1][i3]] = hd[1][i3];
                end
                hv[m][i0] = v && (op != NOP);
                ha[m][i0] = rd;
                hd[m][i0] = alu(op, m_rf[m][s1], m_rf[m][s2], {s1, s2});
                if (m == 0 && hv[0][i0] && rd != 3'd0) m_rf[0][rd] = hd[0][i0];
            end
        end
        @(posedge clk);
        #1;
        chk("fwd_valid", f_valid, hv[0][i2]);
        chk("leg_valid", l_valid, hv[1][i2]);
        if (hv[0][i2]) begin
            chk("fwd_data", f_aluout, hd[0][i2]);
            chk("fwd_wb", f_wb, ha[0][i2]);
        end
        if (hv[1][i2]) begin
            chk("leg_data", l_aluout, hd[1][i2]);
            chk("leg_wb", l_wb, ha[1][i2]);
        end
        chk("fwd_cnt", f_cnt, m_cnt[0]);
        chk("leg_cnt", l_cnt, m_cnt[1]);
        $display("cyc %0d rst=%b v=%b instr=%h fwd=%b:%h@%0d leg=%b:%h@%0d cnt=%0d/%0d",
                 e, rv, v, ins, f_valid, f_aluout, f_wb, l_valid, l_aluout, l_wb, f_cnt, l_cnt);
    endtask

    task automatic bubble();
        step(1'b1, 1'b0, 12'h000);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 12'h000);
        step(1'b0, 1'b0, 12'h000);
    endtask

    initial begin
        // Reset values, then ADD r1,r0,r0
        do_reset();
        chk("rst_aluout", f_aluout, 16'h0000);
        chk("rst_valid", f_valid, 1'b0);
        chk("rst_cnt", f_cnt, 16'd0);
        step(1'b1, 1'b1, enc(ADD, 3'd1, 3'd0, 3'd0));
        bubble();
        bubble();
        chk("add_r0_data", f_aluout, 16'h0000);
        chk("add_r0_valid", f_valid, 1'b1);

        // LDI latency and single-cycle valid
        step(1'b1, 1'b1, enc(LDI, 3'd1, 3'd5, 3'd2));
        bubble();
        bubble();
        chk("ldi_data", f_aluout, 16'h002A);
        chk("ldi_wb", f_wb, 3'd1);
        chk("ldi_valid", f_valid, 1'b1);
        bubble();
        chk("ldi_valid_drop", f_valid, 1'b0);

        // Back-to-back dependent chain
        do_reset();
        step(1'b1, 1'b1, enc(LDI, 3'd1, 3'd0, 3'd5));
        step(1'b1, 1'b1, enc(LDI, 3'd2, 3'd0, 3'd3));
        step(1'b1, 1'b1, enc(ADD, 3'd3, 3'd1, 3'd2));
        chk("chain_ldi5", f_aluout, 16'd5);
        step(1'b1, 1'b1, enc(SUB, 3'd4, 3'd3, 3'd1));
        chk("chain_ldi3", f_aluout, 16'd3);
        step(1'b1, 1'b1, enc(NOP, 3'd5, 3'd1, 3'd1));
        chk("chain_add", f_aluout, 16'd8);
        chk("leg_add_stale", l_aluout, 16'h0000);
        bubble();
        chk("chain_sub", f_aluout, 16'd3);
        bubble();
        chk("chain_cnt", f_cnt, 16'd4);
        chk("nop_no_valid", f_valid, 1'b0);

        // Legacy mode with two NOPs before the dependent ADD
        do_reset();
        step(1'b1, 1'b1, enc(LDI, 3'd1, 3'd0, 3'd5));
        step(1'b1, 1'b1, enc(LDI, 3'd2, 3'd0, 3'd3));
        step(1'b1, 1'b1, enc(NOP, 3'd0, 3'd0, 3'd0));
        step(1'b1, 1'b1, enc(NOP, 3'd0, 3'd0, 3'd0));
        step(1'b1, 1'b1, enc(ADD, 3'd3, 3'd1, 3'd2));
        bubble();
        bubble();
        chk("leg_add_nops", l_aluout, 16'h0008);
        chk("fwd_add_nops", f_aluout, 16'h0008);

        // r0 discard and wrap-around
        do_reset();
        step(1'b1, 1'b1, enc(LDI, 3'd0, 3'd0, 3'd7));
        step(1'b1, 1'b1, enc(ADD, 3'd5, 3'd0, 3'd0));
        step(1'b1, 1'b1, enc(LDI, 3'd1, 3'd7, 3'd7));
        chk("r0_ldi_shown", f_aluout, 16'd7);
        chk("r0_ldi_wb", f_wb, 3'd0);
        step(1'b1, 1'b1, enc(SUB, 3'd2, 3'd0, 3'd1));
        chk("r0_reads_zero", f_aluout, 16'h0000);
        step(1'b1, 1'b1, enc(SLT, 3'd3, 3'd2, 3'd1));
        step(1'b1, 1'b1, enc(ADD, 3'd4, 3'd2, 3'd2));
        chk("sub_wrap", f_aluout, 16'hFFC1);
        bubble();
        chk("slt_signed", f_aluout, 16'h0001);
        bubble();
        chk("add_wrap", f_aluout, 16'hFF82);

        // Reset while instructions are in flight
        do_reset();
        step(1'b1, 1'b1, enc(LDI, 3'd1, 3'd1, 3'd1));
        step(1'b1, 1'b1, enc(LDI, 3'd2, 3'd0, 3'd4));
        step(1'b0, 1'b0, 12'h000);
        chk("midrst_valid0", f_valid, 1'b0);
        step(1'b1, 1'b1, enc(ADD, 3'd3, 3'd1, 3'd2));
        chk("midrst_valid1", f_valid, 1'b0);
        bubble();
        chk("midrst_valid2", f_valid, 1'b0);
        bubble();
        chk("midrst_add_valid", f_valid, 1'b1);
        chk("midrst_add_data", f_aluout, 16'h0000);

        // Random traffic against the model
        do_reset();
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
                 12'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pipelined_regfile_fwd.md
PIPELINED_REGFILE_FWD -- requirements
Module: pipelined_regfile_fwd

Interface
REQ-001 Parameter DW, default 16: data and register width in bits.
REQ-002 Parameter AW, default 3: register address width; register count is 2^AW; DW >= 2*AW is required.
REQ-003 Parameter FWD_EN, default 1: 1 enables operand forwarding; 0 reads operands from the register file only (legacy mode).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous reset, active-low.
REQ-006 instr_valid  input  1  instr is a valid instruction this cycle.
REQ-007 instr  input  3+3*AW  fields {op[2:0], rd, rs1, rs2}, MSB first.
REQ-008 aluout  output  DW  registered result of the instruction in the writeback stage.
REQ-009 aluout_valid  output  1  aluout holds a valid result this cycle.
REQ-010 wb_addr  output  AW  destination register of aluout.
REQ-011 instr_cnt  output  16  count of results produced, saturating.

Function
REQ-012 The pipeline SHALL have three stages: S1 decode/operand fetch, S2 execute, S3 writeback; each stage carries a valid bit.
REQ-013 An instruction sampled at edge k SHALL latch operands at edge k+1, present its result on aluout with aluout_valid=1 after edge k+2, and write the register file at edge k+3.
REQ-014 The block SHALL accept one instruction per cycle with no stall; instr_valid=0 inserts a bubble that produces no result and no write.
REQ-015 Opcodes: 000 ADD, 001 SUB (rs1-rs2), 010 AND, 011 OR, 100 XOR, 101 SLT (1 if rs1<rs2 signed, else 0), 110 LDI (rd <= zero-extended {rs1,rs2}), 111 NOP (no result, no write, aluout_valid stays 0).
REQ-016 Arithmetic SHALL wrap modulo 2^DW; no carry or overflow flags are produced.
REQ-017 Register 0 SHALL read as zero at all times; writes to r0 are discarded, but the result still appears on aluout.
REQ-018 With FWD_EN=1, each S1 operand SHALL use the first match in this order: S2 ALU result (matching rd, S2 valid); S3 aluout (matching wb_addr, S3 valid); register file.
REQ-019 Forwarding SHALL never apply to source address 0 or to bubbles/NOPs.
REQ-020 With FWD_EN=0, operands SHALL come from the register file as it stands before the current edge's write; dependent instructions closer than 3 cycles read stale values.
REQ-021 instr_cnt SHALL increment on each cycle aluout_valid=1 and hold at 16'hFFFF.

Reset
REQ-022 While rst=0 at a rising edge, the block SHALL clear all stage valid bits, all registers to 0, aluout to 0, aluout_valid to 0, wb_addr to 0 and instr_cnt to 0.
REQ-023 Reset mid-operation SHALL discard in-flight instructions, and no register write SHALL occur at the reset edge.
REQ-024 The first instruction SHALL be accepted at the first edge with rst=1.

Verification (DW=16, AW=3, FWD_EN=1 unless noted)
REQ-025 Reset: hold rst=0 for 2 cycles -> aluout=0, aluout_valid=0, instr_cnt=0; ADD r1,r0,r0 then gives aluout=0x0000.
REQ-026 Latency and LDI: LDI r1,{5,2} at edge k -> after edge k+2, aluout=0x002A, wb_addr=1, aluout_valid=1 for exactly one cycle.
REQ-027 Back-to-back forwarding: LDI r1,#5; LDI r2,#3; ADD r3,r1,r2; SUB r4,r3,r1 on consecutive cycles -> aluout=5,3,8,3 on consecutive cycles; instr_cnt=4.
REQ-028 Legacy mode (FWD_EN=0): same sequence -> ADD gives 0x0000; with 2 NOPs inserted before the ADD, it gives 0x0008.
REQ-029 r0 and wrap behaviour:
- LDI r0,#7 then ADD r5,r0,r0 -> 0x0000.
- LDI r1,#63; SUB r2,r0,r1 -> 0xFFC1.
- SLT r3,r2,r1 -> 0x0001.
- ADD r4,r2,r2 -> 0xFF82.
REQ-030 Reset mid-op:
- Issue LDI r1,#9 and LDI r2,#4, then drive rst=0 on the next edge.
- Required: no aluout_valid afterwards.
- After release, ADD r3,r1,r2 -> 0x0000.
